// File: rtl/core_package.sv
// Shared definitions for the execute stage: ALU opcode encoding.
package core_package;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer. Borrows the shared ALU for
// all add/subtract work (magnitudes, shift-add multiply, restoring divide,
// sign fix-up) and keeps shift registers and compares locally.
module muldiv_sequencer
  import core_package::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o,
  output alu_op_e         alu_opcode_o,
  output logic [XLEN-1:0] alu_operand_a_o,
  output logic [XLEN-1:0] alu_operand_b_o,
  input  logic [XLEN-1:0] alu_result_i
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_NEG,
    S_DONE
  } state_e;

  state_e          state;
  logic [2:0]      f3;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  // hi holds the product high word or the partial remainder;
  // lo holds the multiplier/product low word or the quotient;
  // opnd holds the multiplicand or the divisor.
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [4:0]      cnt;

  // Decode of the latched operation
  logic is_div;
  logic is_rem;
  logic is_mulh;
  logic neg_res;
  logic [XLEN-1:0] sel_result;

  assign is_div     = f3[2];
  assign is_rem     = f3[2] & f3[1];
  assign is_mulh    = ~f3[2] & (f3[1:0] != 2'b00);
  assign neg_res    = is_rem ? a_neg : (a_neg ^ b_neg);
  assign sel_result = (is_rem || is_mulh) ? hi : lo;

  // Accept-time decode from the request inputs
  logic in_a_neg;
  logic in_b_neg;
  logic div_zero;
  logic div_ovf;
  logic [XLEN-1:0] fast_result;

  assign in_a_neg = req_a_i[XLEN-1] &
                    ((req_funct3_i == 3'b001) || (req_funct3_i == 3'b010) ||
                     (req_funct3_i == 3'b100) || (req_funct3_i == 3'b110));
  assign in_b_neg = req_b_i[XLEN-1] &
                    ((req_funct3_i == 3'b001) || (req_funct3_i == 3'b100) ||
                     (req_funct3_i == 3'b110));
  assign div_zero = req_funct3_i[2] && (req_b_i == '0);
  assign div_ovf  = req_funct3_i[2] && !req_funct3_i[0] &&
                    (req_a_i == MIN_NEG) && (req_b_i == '1);
  assign fast_result = div_zero ? (req_funct3_i[1] ? req_a_i : '1)
                                : (req_funct3_i[1] ? '0 : MIN_NEG);

  // Iteration helpers: shifted remainder, divide accept bit, multiply carry
  logic [XLEN-1:0] sh;
  logic            div_ok;
  logic            mul_carry;

  assign sh        = {hi[XLEN-2:0], lo[XLEN-1]};
  assign div_ok    = hi[XLEN-1] | !(sh < opnd);
  assign mul_carry = alu_result_i < opnd;

  assign req_ready_o = (state == S_IDLE);

  // ALU drive selected by the current phase; ADD 0,0 when not in use
  always_comb begin
    alu_opcode_o    = ALU_ADD;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    unique case (state)
      S_ABS_A: begin
        alu_opcode_o    = ALU_SUB;
        alu_operand_b_o = a_reg;
      end
      S_ABS_B: begin
        alu_opcode_o    = ALU_SUB;
        alu_operand_b_o = b_reg;
      end
      S_ITER: begin
        if (is_div) begin
          alu_opcode_o    = ALU_SUB;
          alu_operand_a_o = sh;
          alu_operand_b_o = opnd;
        end else begin
          alu_opcode_o    = ALU_ADD;
          alu_operand_a_o = hi;
          alu_operand_b_o = opnd;
        end
      end
      S_NEG: begin
        // High-word negation subtracts from all-ones when the low word is
        // nonzero, which folds in the borrow of the 64-bit negate.
        alu_opcode_o    = ALU_SUB;
        alu_operand_a_o = (is_mulh && (lo != '0)) ? '1 : '0;
        alu_operand_b_o = sel_result;
      end
      default: ;
    endcase
  end

  // Sequencer state, datapath registers and registered response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      f3            <= '0;
      a_neg         <= 1'b0;
      b_neg         <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      hi            <= '0;
      lo            <= '0;
      opnd          <= '0;
      cnt           <= '0;
      resp_valid_o  <= 1'b0;
      resp_result_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            f3    <= req_funct3_i;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            a_reg <= req_a_i;
            b_reg <= req_b_i;
            if (div_zero || div_ovf) begin
              resp_result_o <= fast_result;
              resp_valid_o  <= 1'b1;
              state         <= S_DONE;
            end else begin
              state <= S_ABS_A;
            end
          end
        end
        S_ABS_A: begin
          if (a_neg) a_reg <= alu_result_i;
          state <= S_ABS_B;
        end
        S_ABS_B: begin
          hi  <= '0;
          cnt <= '0;
          if (is_div) begin
            lo   <= a_reg;
            opnd <= b_neg ? alu_result_i : b_reg;
          end else begin
            lo   <= b_neg ? alu_result_i : b_reg;
            opnd <= a_reg;
          end
          state <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            lo <= {lo[XLEN-2:0], div_ok};
            hi <= div_ok ? alu_result_i : sh;
          end else if (lo[0]) begin
            hi <= {mul_carry, alu_result_i[XLEN-1:1]};
            lo <= {alu_result_i[0], lo[XLEN-1:1]};
          end else begin
            hi <= {1'b0, hi[XLEN-1:1]};
            lo <= {hi[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_NEG;
        end
        S_NEG: begin
          resp_result_o <= neg_res ? alu_result_i : sel_result;
          resp_valid_o  <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with a behavioural ALU and a
// 64-bit arithmetic reference model of the RV32M results and latency.
module tb_muldiv_sequencer;
  import core_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  alu_op_e     alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_funct3_i(req_funct3),
    .req_a_i(req_a),
    .req_b_i(req_b),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_result_o(resp_result),
    .alu_opcode_o(alu_opcode),
    .alu_operand_a_o(alu_a),
    .alu_operand_b_o(alu_b),
    .alu_result_i(alu_result)
  );

  // Shared combinational ALU (only ADD/SUB matter here)
  always_comb begin
    alu_result = '0;
    if (alu_opcode == ALU_ADD) alu_result = alu_a + alu_b;
    else if (alu_opcode == ALU_SUB) alu_result = alu_a - alu_b;
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs, ps;
    logic [63:0] ua, ub, pu;
    logic signed [31:0] as32, bs32, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ubs = {32'b0, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as32 = a;
    bs32 = b;
    case (f3)
      3'b000: begin pu = ua * ub; return pu[31:0]; end
      3'b001: begin ps = sa * sb; return ps[63:32]; end
      3'b010: begin ps = sa * ubs; return ps[63:32]; end
      3'b011: begin pu = ua * ub; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = as32 / bs32; return q;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = as32 % bs32; return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 36;
  endfunction

  // Present a request and return just after its accept edge; false on timeout
  task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_req_timeout: req_ready=%0b required 1", req_ready);
      ok = 1'b0;
      return;
    end
    req_funct3 = f3; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count edges from the accept edge until resp_valid is seen
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_checked(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    int lat;
    logic [31:0] exp_res;
    int exp_lat;
    exp_res = ref_model(f3, a, b);
    exp_lat = ref_latency(f3, a, b);
    send_req(f3, a, b, ok);
    if (!ok) return;
    wait_resp(lat);
    vectors++;
    if (!resp_valid || lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: f3=%0d a=%h b=%h got %0d cycles required %0d", name, f3, a, b, lat, exp_lat);
    end
    vectors++;
    if (resp_result !== exp_res) begin
      miscompares++;
      $display("FAIL %s_result: f3=%0d a=%h b=%h got %h required %h", name, f3, a, b, resp_result, exp_res);
    end
    handshake();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || resp_result !== 32'h0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b result=%h ready=%b required 0 00000000 1", resp_valid, resp_result, req_ready);
    end
    vectors++;
    if (alu_opcode !== ALU_ADD || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_alu_idle: op=%0d a=%h b=%h required ADD 0 0", alu_opcode, alu_a, alu_b);
    end
  endtask

  task automatic test_directed;
    logic [2:0]  f3s [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                              3'b101, 3'b110, 3'b100, 3'b111};
    logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'd9};
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (ref_model(f3s[i], as[i], bs[i]) !== exp[i]) begin
        miscompares++;
        $display("FAIL directed_model_%0d: model=%h required %h", i, ref_model(f3s[i], as[i], bs[i]), exp[i]);
      end
      run_checked($sformatf("directed_%0d", i), f3s[i], as[i], bs[i]);
    end
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 200; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_checked("random", f3, a, b);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int lat;
    logic [31:0] held;
    int bad = 0;
    send_req(3'b000, 32'd7, 32'hFFFF_FFFD, ok);
    if (!ok) return;
    wait_resp(lat);
    held = resp_result;
    vectors++;
    if (held !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL bp_result: got %h required ffffffeb", held);
    end
    // Next request waits on the bus throughout the stalled response
    req_funct3 = 3'b101; req_a = 32'd1000; req_b = 32'd9; req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_result !== held || req_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d stalled cycles lost valid/result or showed ready, required 0", bad);
    end
    handshake();
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_after_handshake: valid=%b ready=%b required 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_accept: ready=%b required 0", req_ready);
    end
    wait_resp(lat);
    vectors++;
    if (lat != 36 || resp_result !== 32'd111) begin
      miscompares++;
      $display("FAIL bp_next_result: lat=%0d result=%h required 36 0000006f", lat, resp_result);
    end
    handshake();
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    int seen = 0;
    send_req(3'b100, 32'hFFFF_FF00, 32'd3, ok);
    if (!ok) return;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midreset_no_resp: %0d valid cycles required 0", seen);
    end
    run_checked("after_reset", 3'b110, 32'hFFFF_FF00, 32'd7);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide instructions, built on top of the shared 32-bit combinational ALU. It owns the ALU opcode and operand ports while busy and uses ALU_ADD and ALU_SUB for the iterative work. It keeps the shift registers, sign bookkeeping and local carry/borrow compare itself. It sits in the execute stage beside the ALU, with a valid/ready request interface and a valid/ready response interface.

Parameters:
XLEN, 32, datapath width; must equal the ALU width; only 32 is supported.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  sequencer can accept a request (high only in IDLE)
req_funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a_i  input  32  rs1 operand
req_b_i  input  32  rs2 operand
resp_valid_o  output  1  result valid
resp_ready_i  input  1  consumer accepts the result
resp_result_o  output  32  result
alu_opcode_o  output  core_package::alu_op_e  opcode driven to the ALU
alu_operand_a_o  output  32  ALU operand A
alu_operand_b_o  output  32  ALU operand B
alu_result_i  input  32  ALU result (combinational, same cycle)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE; resp_valid_o=0; resp_result_o=0; all internal registers 0.
- Reset mid-operation: returns to IDLE on the next edge, drops the operation, emits no response.
- ALU drive when idle: in IDLE and DONE the ALU outputs are alu_opcode_o=ALU_ADD, operands 0.
- Accept: a request is taken in cycle T when req_valid_i && req_ready_o. Operands, funct3 and sign flags are latched.
  - a_neg = a[31] for MULH, MULHSU, DIV, REM; otherwise 0.
  - b_neg = b[31] for MULH, DIV, REM; otherwise 0.
- Fast path, decided at accept: enter DONE at T+1, so resp_valid_o=1 at T+1.
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- Normal path state sequence (fixed latency, resp_valid_o first high at T+36):
  - ABS_A (T+1): ALU_SUB(0, a). Register the result as the magnitude if a_neg, else keep a.
  - ABS_B (T+2): ALU_SUB(0, b). Same rule with b_neg.
  - ITER (T+3..T+34): exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 to exit.
  - NEG (T+35): sign fix-up, then DONE at T+36.
- Multiply iteration: hi=0, lo=|b| multiplier, mcand=|a|.
  - If lo[0]: ALU_ADD(hi, mcand); carry = (alu_result_i < mcand) by a local unsigned compare; {hi,lo} <= {carry, alu_result_i, lo} >> 1.
  - Else: {hi,lo} <= {1'b0, hi, lo} >> 1. The ALU is still driven with ADD, and its result is ignored.
- Divide iteration (restoring): rem=0, quot=|a|, div=|b|.
  - sh = {rem[30:0], quot[31]}; ALU_SUB(sh, div).
  - ok = rem[31] | !(sh < div).
  - quot <= {quot[30:0], ok}; rem <= ok ? alu_result_i : sh.
- NEG, result negation: negate when neg_res is set.
  - neg_res = a_neg^b_neg for multiplies and DIV; a_neg for REM.
  - MUL and divide results: ALU_SUB(0, x).
  - MULH/MULHSU high word: ALU_SUB((lo!=0) ? 0xFFFFFFFF : 0, hi). This applies the 64-bit borrow.
  - If no negation is needed, the ALU is still driven and the result is ignored.
- Result select: MUL returns lo; MULH* return hi; DIV* return quot; REM* return rem.
- DONE: resp_valid_o and resp_result_o are held stable until resp_ready_i; then IDLE next cycle.
  - req_ready_o=0 in DONE, so no back-to-back accept in the same cycle as the response handshake.
- Protocol rules: req_* inputs are ignored outside IDLE. resp_ready_i outside DONE has no effect.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> resp_result_o=0xFFFFFFEB, resp_valid_o rises exactly 36 cycles after accept.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF at T+1; REM a=0x80000000, b=0xFFFFFFFF -> 0 at T+1; DIV same operands -> 0x80000000.
- Back-pressure: hold resp_ready_i=0 for 5 cycles in DONE -> result stable and req_ready_o=0 throughout; accept the next request only after the response handshake.
- Assert rst_i at T+10 of a DIV -> IDLE next cycle, req_ready_o=1, resp_valid_o stays 0, and the next request completes correctly.
